// File: rtl/npu_out_pkg.sv
// npu_out_pkg: shared types and constants for the NPU output collector.
//   OUT_LANES          - activation lanes produced by the AP stage
//   OUT_BYTES_PER_WORD - bytes packed into one output word
//   arb_state_e        - word-port arbiter states
//   out_word_t         - buffered word: payload plus valid-byte count
package npu_out_pkg;

   localparam int unsigned OUT_LANES          = 8;
   localparam int unsigned OUT_BYTES_PER_WORD = 4;
   localparam int unsigned OUT_LANE_W         = 3;
   localparam int unsigned OUT_BYTES_W        = 3;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [31:0]            data;
      logic [OUT_BYTES_W-1:0] bytes;
   } out_word_t;

endpackage

// File: rtl/out_lane_packer.sv
// out_lane_packer: one activation lane. Packs bytes MSB-first into words,
// buffers them in a small FIFO, tracks overflow and handles flush.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   act_in, act_en  - incoming byte and its valid
//   flush           - push any partial word when the FIFO has room
//   pop             - arbiter consumes the current head this edge
//   post_data_c/post_bytes_c/post_valid_c - head as it will be after this
//                     edge's pop (equals the current head when pop=0)
//   overflow        - sticky drop flag
//   empty_c         - packer and FIFO both empty
//   drop_c          - byte dropped this cycle (only with NPU_OUTCOL_STATS_EN)
module out_lane_packer
   import npu_out_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  act_in,
   input  logic        act_en,
   input  logic        flush,
   input  logic        pop,
   output logic [31:0] post_data_c,
   output logic [2:0]  post_bytes_c,
   output logic        post_valid_c,
   output logic        overflow,
   output logic        empty_c
`ifdef NPU_OUTCOL_STATS_EN
   ,output logic       drop_c
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [2:0]    cnt_q, cnt_d;
   logic [31:0]   word_q, word_d;
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, rd_post;
   logic          ovf_q, ovf_d;
   out_word_t     mem_q [FIFO_DEPTH];

   logic [31:0]   eff_word;
   logic [2:0]    eff_cnt;
   logic          full, push_req, push, drop;

   // Packer state including this cycle's byte, then push/drop decision.
   always_comb begin
      eff_word = word_q;
      eff_cnt  = cnt_q;
      if (act_en) begin
         eff_word = word_q | ({act_in, 24'h0} >> {cnt_q[1:0], 3'b000});
         eff_cnt  = cnt_q + 3'd1;
      end
      full     = (wr_q - rd_q) == PW'(FIFO_DEPTH);
      push_req = (eff_cnt == 3'(OUT_BYTES_PER_WORD)) || (flush && (eff_cnt != 3'd0));
      // a same-edge pop frees a slot for the push
      push     = push_req && (!full || pop);
      drop     = (eff_cnt == 3'(OUT_BYTES_PER_WORD)) && !push;

      cnt_d  = eff_cnt;
      word_d = eff_word;
      if (push) begin
         cnt_d  = 3'd0;
         word_d = 32'h0;
      end else if (drop) begin
         cnt_d  = cnt_q;
         word_d = word_q;
      end
      ovf_d = ovf_q | drop;
      wr_d  = wr_q + PW'(push);
      rd_d  = rd_q + PW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= 3'd0;
         word_q <= 32'h0;
         wr_q   <= '0;
         rd_q   <= '0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         ovf_q  <= ovf_d;
      end
   end

   // Storage needs no reset; pointers define occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q[AW-1:0]] <= '{data: eff_word, bytes: eff_cnt};
      end
   end

   // Lets the arbiter re-grant in the same edge as a pop.
   assign rd_post      = pop ? rd_q + PW'(1) : rd_q;
   assign post_valid_c = wr_q != rd_post;
   assign post_data_c  = mem_q[rd_post[AW-1:0]].data;
   assign post_bytes_c = mem_q[rd_post[AW-1:0]].bytes;
   assign overflow     = ovf_q;
   assign empty_c      = (cnt_q == 3'd0) && (wr_q == rd_q);
`ifdef NPU_OUTCOL_STATS_EN
   assign drop_c       = drop;
`endif

endmodule

// File: rtl/npu_out_collector.sv
// npu_out_collector: collects the 8-lane activation stream into 32-bit words
// and drains them over one valid/ready port with round-robin lane arbitration.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   act_in, act_en, flush      - activation bytes (lane 0 in MSB), valids, flush
//   m_data, m_lane, m_bytes    - output word, source lane, valid byte count
//   m_valid, m_ready           - output handshake
//   overflow                   - sticky per-lane drop flags (bit LANES-1-k = lane k)
//   idle                       - nothing buffered anywhere
//   drop_cnt                   - saturating dropped-byte count (NPU_OUTCOL_STATS_EN)
module npu_out_collector
   import npu_out_pkg::*;
#(
   parameter int unsigned LANES      = OUT_LANES,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [8*LANES-1:0]   act_in,
   input  logic [LANES-1:0]     act_en,
   input  logic                 flush,
   output logic [31:0]          m_data,
   output logic [2:0]           m_lane,
   output logic [2:0]           m_bytes,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [LANES-1:0]     overflow,
   output logic                 idle
`ifdef NPU_OUTCOL_STATS_EN
   ,output logic [15:0]         drop_cnt
`endif
);

   localparam int unsigned LW = OUT_LANE_W;

   arb_state_e      state_q, state_d;
   logic [LW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [31:0]     m_data_q, m_data_d;
   logic [LW-1:0]   m_lane_q, m_lane_d;
   logic [2:0]      m_bytes_q, m_bytes_d;

   logic [LANES-1:0] pop_c, post_valid_c, empty_c;
   logic [31:0]      post_data_c  [LANES];
   logic [2:0]       post_bytes_c [LANES];
   logic [LANES-1:0] ovf_c;
`ifdef NPU_OUTCOL_STATS_EN
   logic [LANES-1:0] drop_c;
`endif

   logic            hs, found;
   logic [LW-1:0]   next_lane, start, idx, grant;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      out_lane_packer #(.FIFO_DEPTH(FIFO_DEPTH)) u_lane (
         .clk          (clk),
         .reset        (reset),
         .act_in       (act_in[8*LANES-1-8*k -: 8]),
         .act_en       (act_en[LANES-1-k]),
         .flush        (flush),
         .pop          (pop_c[k]),
         .post_data_c  (post_data_c[k]),
         .post_bytes_c (post_bytes_c[k]),
         .post_valid_c (post_valid_c[k]),
         .overflow     (ovf_c[k]),
         .empty_c      (empty_c[k])
`ifdef NPU_OUTCOL_STATS_EN
         ,.drop_c      (drop_c[k])
`endif
      );
      assign overflow[LANES-1-k] = ovf_c[k];
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ARB;
         rr_ptr_q  <= '0;
         m_data_q  <= 32'h0;
         m_lane_q  <= '0;
         m_bytes_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         m_data_q  <= m_data_d;
         m_lane_q  <= m_lane_d;
         m_bytes_q <= m_bytes_d;
      end
   end

   // Next state: round-robin search over post-pop occupancy, latch grant.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      m_data_d  = m_data_q;
      m_lane_d  = m_lane_q;
      m_bytes_d = m_bytes_q;
      hs        = (state_q == HOLD) && m_ready;
      next_lane = (m_lane_q == LW'(LANES-1)) ? '0 : m_lane_q + LW'(1);
      start     = hs ? next_lane : rr_ptr_q;
      found     = 1'b0;
      grant     = '0;
      idx       = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         idx = LW'((int'(start) + i) % int'(LANES));
         if (!found && post_valid_c[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
      case (state_q)
         ARB: begin
            if (found) begin
               state_d   = HOLD;
               m_data_d  = post_data_c[grant];
               m_lane_d  = grant;
               m_bytes_d = post_bytes_c[grant];
            end
         end
         HOLD: begin
            if (hs) begin
               rr_ptr_d = next_lane;
               if (found) begin
                  m_data_d  = post_data_c[grant];
                  m_lane_d  = grant;
                  m_bytes_d = post_bytes_c[grant];
               end else begin
                  state_d = ARB;
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Outputs decoded from state: valid in HOLD, pop granted lane on handshake.
   always_comb begin
      m_valid = 1'b0;
      pop_c   = '0;
      if (state_q == HOLD) begin
         m_valid = 1'b1;
         if (m_ready) begin
            pop_c[m_lane_q] = 1'b1;
         end
      end
   end

   assign m_data  = m_data_q;
   assign m_lane  = m_lane_q;
   assign m_bytes = m_bytes_q;
   assign idle    = (&empty_c) && (state_q == ARB);

`ifdef NPU_OUTCOL_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [16:0] drop_sum;

   // Saturating sum of all lanes' drops this cycle.
   always_comb begin
      drop_sum = {1'b0, drop_cnt_q};
      for (int k = 0; k < int'(LANES); k++) begin
         drop_sum = drop_sum + 17'(drop_c[k]);
      end
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (reset) drop_cnt_q <= 16'h0;
      else       drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_npu_out_collector.sv
// Scoreboard bench for npu_out_collector: stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake.
module tb_npu_out_collector;

   localparam int LANES = 8;
   localparam int DEPTH = 4;

   logic               clk;
   logic               reset;
   logic [8*LANES-1:0] act_in;
   logic [LANES-1:0]   act_en;
   logic               flush;
   logic [31:0]        m_data;
   logic [2:0]         m_lane;
   logic [2:0]         m_bytes;
   logic               m_valid;
   logic               m_ready;
   logic [LANES-1:0]   overflow;
   logic               idle;
`ifdef NPU_OUTCOL_STATS_EN
   logic [15:0]        drop_cnt;
`endif

   npu_out_collector #(.LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .act_in   (act_in),
      .act_en   (act_en),
      .flush    (flush),
      .m_data   (m_data),
      .m_lane   (m_lane),
      .m_bytes  (m_bytes),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .overflow (overflow),
      .idle     (idle)
`ifdef NPU_OUTCOL_STATS_EN
      ,.drop_cnt(drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [2:0]  l;
      logic [2:0]  b;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [31:0] d, input int l, input int b);
      exp_t e;
      e.d = d;
      e.l = 3'(l);
      e.b = 3'(b);
      q.push_back(e);
   endtask

   task automatic clr_in();
      act_in = '0;
      act_en = '0;
   endtask

   task automatic set_byte(input int k, input logic [7:0] v);
      act_in[8*LANES-1-8*k -: 8] = v;
      act_en[LANES-1-k]          = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(name, 32'(q.size()), 32'd0);
   endtask

   // Monitor: hold stability and scoreboard compare on each handshake.
   logic        hold_v = 1'b0;
   logic [31:0] hd;
   logic [2:0]  hl, hb;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            total++;
            if (!m_valid || m_data !== hd || m_lane !== hl || m_bytes !== hb) begin
               bad++;
               $display("FAIL hold_stable: got v=%b d=%h l=%0d b=%0d expected v=1 d=%h l=%0d b=%0d",
                        m_valid, m_data, m_lane, m_bytes, hd, hl, hb);
            end
         end
         if (m_valid && m_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_word: got d=%h l=%0d b=%0d expected none", m_data, m_lane, m_bytes);
            end else begin
               e = q.pop_front();
               if (m_data !== e.d || m_lane !== e.l || m_bytes !== e.b) begin
                  bad++;
                  $display("FAIL word: got d=%h l=%0d b=%0d expected d=%h l=%0d b=%0d",
                           m_data, m_lane, m_bytes, e.d, e.l, e.b);
               end
            end
         end
         hold_v = m_valid && !m_ready;
         hd     = m_data;
         hl     = m_lane;
         hb     = m_bytes;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      flush   = 1'b0;
      m_ready = 1'b1;
      clr_in();
      repeat (3) tick();
      reset = 1'b0;

      // reset state
      check("rst_m_valid",  32'(m_valid),  32'd0);
      check("rst_m_data",   m_data,        32'h0);
      check("rst_m_lane",   32'(m_lane),   32'd0);
      check("rst_m_bytes",  32'(m_bytes),  32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_idle",     32'(idle),     32'd1);

      // lane 0 single word, latency t+2
      exp_push(32'h11223344, 0, 4);
      set_byte(0, 8'h11); tick();
      set_byte(0, 8'h22); tick();
      set_byte(0, 8'h33); tick();
      set_byte(0, 8'h44); tick();
      clr_in();
      check("lat_t1_valid", 32'(m_valid), 32'd0);
      tick();
      check("lat_t2_valid", 32'(m_valid), 32'd1);
      check("lat_t2_data",  m_data,       32'h11223344);
      check("lat_t2_lane",  32'(m_lane),  32'd0);
      check("lat_t2_bytes", 32'(m_bytes), 32'd4);
      tick();
      check("pulse_valid",  32'(m_valid), 32'd0);
      check("t1_idle",      32'(idle),    32'd1);

      // reset returns rr_ptr to lane 0
      reset = 1'b1; tick(); reset = 1'b0;

      // all lanes at once, lane k bytes = k, back-to-back drain
      for (int k = 0; k < LANES; k++) exp_push({4{8'(k)}}, k, 4);
      for (int j = 0; j < 4; j++) begin
         for (int k = 0; k < LANES; k++) set_byte(k, 8'(k));
         tick();
      end
      clr_in();
      tick();
      for (int i = 0; i < LANES; i++) begin
         check("burst_valid", 32'(m_valid), 32'd1);
         tick();
      end
      check("burst_end_valid", 32'(m_valid), 32'd0);
      wait_drain("burst_drain", 4);

      // stall 10 cycles while holding, then one word per cycle; rr starts at lane 0
      m_ready = 1'b0;
      for (int k = 0; k < LANES; k++)
         exp_push({8'(16*k), 8'(16*k+1), 8'(16*k+2), 8'(16*k+3)}, k, 4);
      for (int j = 0; j < 4; j++) begin
         for (int k = 0; k < LANES; k++) set_byte(k, 8'(16*k+j));
         tick();
      end
      clr_in();
      repeat (10) tick();
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_data",  m_data,       32'h00010203);
      check("stall_lane",  32'(m_lane),  32'd0);
      m_ready = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         check("stall_drain_valid", 32'(m_valid), 32'd1);
         tick();
      end
      wait_drain("stall_drain", 4);

      // partial word via flush on lane 3
      exp_push(32'hA0A1A200, 3, 3);
      set_byte(3, 8'hA0); tick();
      set_byte(3, 8'hA1); tick();
      set_byte(3, 8'hA2); tick();
      clr_in();
      check("pre_flush_idle", 32'(idle), 32'd0);
      flush = 1'b1; tick(); flush = 1'b0;
      wait_drain("flush_drain", 10);
      tick();
      check("flush_idle", 32'(idle), 32'd1);

      // rr_ptr now lane 4: lanes 2 and 6 pending -> 6 first, then wrap to 2
      m_ready = 1'b0;
      exp_push(32'h61626364, 6, 4);
      exp_push(32'h21222324, 2, 4);
      for (int j = 0; j < 4; j++) begin
         set_byte(2, 8'(8'h21 + j));
         set_byte(6, 8'(8'h61 + j));
         tick();
      end
      clr_in();
      tick();
      m_ready = 1'b1;
      wait_drain("rr_drain", 10);

      // overflow on lane 5 (overflow bit 2) with consumer stalled
      m_ready = 1'b0;
      for (int i = 0; i < 4*DEPTH; i++) begin
         set_byte(5, 8'(8'h50 + i));
         tick();
      end
      check("ovf_before", 32'(overflow), 32'h00);
      for (int i = 4*DEPTH; i < 4*(DEPTH+1); i++) begin
         set_byte(5, 8'(8'h50 + i));
         tick();
      end
      clr_in();
      check("ovf_set", 32'(overflow), 32'h04);
`ifdef NPU_OUTCOL_STATS_EN
      check("drop_cnt", 32'(drop_cnt), 32'd1);
`endif
      exp_push(32'h50515253, 5, 4);
      exp_push(32'h54555657, 5, 4);
      exp_push(32'h58595A5B, 5, 4);
      exp_push(32'h5C5D5E5F, 5, 4);
      m_ready = 1'b1;
      wait_drain("ovf_drain", 20);
      tick();
      check("ovf_after_valid", 32'(m_valid),  32'd0);
      check("ovf_after_idle",  32'(idle),     32'd0);
      check("ovf_sticky",      32'(overflow), 32'h04);

      // pending word on lane 2, then reset mid-stream
      m_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         set_byte(2, 8'(8'hE0 + j));
         tick();
      end
      clr_in();
      repeat (3) tick();
      check("pre_reset_valid", 32'(m_valid), 32'd1);
      reset = 1'b1;
      q.delete();
      tick();
      reset = 1'b0;
      check("post_reset_valid", 32'(m_valid),  32'd0);
      check("post_reset_ovf",   32'(overflow), 32'h00);
      check("post_reset_idle",  32'(idle),     32'd1);
`ifdef NPU_OUTCOL_STATS_EN
      check("post_reset_drop",  32'(drop_cnt), 32'd0);
`endif

      // lane 5's stale bytes must not leak into the next word
      m_ready = 1'b1;
      exp_push(32'hC0C1C2C3, 5, 4);
      for (int j = 0; j < 4; j++) begin
         set_byte(5, 8'(8'hC0 + j));
         tick();
      end
      clr_in();
      wait_drain("fresh_drain", 10);
      tick();
      check("final_idle", 32'(idle), 32'd1);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/npu_out_collector.md
# npu_out_collector

Downstream stage of the simple NPU top. Consumes the 8-lane, 8-bit activation stream (`out` / `out_en`) produced after ReLU/max-pool. Packs each lane's bytes MSB-first into 32-bit words, buffers them per lane, and drains them over a single valid/ready word port using round-robin lane arbitration toward the output-memory writer.

## Interface
- `LANES`, 8, number of activation lanes; must match the AP output width.
- `FIFO_DEPTH`, 4, words per lane FIFO; power of two, ≥2.
- `clk` input 1, rising-edge clock.
- `reset` input 1, synchronous, active-high.
- `act_in` input 8*LANES, lane k = `act_in[8*LANES-1-8k -: 8]`; lane 0 is the MSB byte.
- `act_en` input LANES, lane k valid = `act_en[LANES-1-k]`.
- `flush` input 1, level request: push partial words.
- `m_data` output 32, packed word; first byte received sits in [31:24].
- `m_lane` output 3, source lane of `m_data`.
- `m_bytes` output 3, valid bytes in `m_data`, 1..4; unused low bytes are zero.
- `m_valid` output 1, word available.
- `m_ready` input 1, consumer accepts.
- `overflow` output LANES, sticky per-lane drop flag, same bit order as `act_en`.
- `idle` output 1, all packers, FIFOs and arbiter empty.

## Operation
- Per lane: a packer holds 0..3 bytes. An enabled byte is appended. When it is the 4th, the full word (`m_bytes` = 4) is pushed to the lane FIFO at the same edge and the packer clears.
- FIFO full, no pop at that edge, and a completing byte arrives: the byte is dropped, the packer is unchanged, and `overflow[k]` is set until reset. A pop at the same edge frees space, so the push succeeds.
- `flush` high: each lane with a non-empty packer pushes a partial word (count = held bytes, including any byte arriving that cycle) whenever its FIFO has room. A lane with an empty packer pushes nothing. A full FIFO defers the push; no drop.
- Arbiter FSM has two states:
  - ARB: `m_valid`=0. If any FIFO is non-empty, latch the head of the first non-empty lane at or after `rr_ptr` (wrapping) into the output registers and go to HOLD.
  - HOLD: `m_valid`=1; `m_data`, `m_lane`, `m_bytes` are stable. On `m_ready`, pop that lane and set `rr_ptr` = lane+1 mod LANES. Then re-arbitrate in the same edge using post-pop occupancy: stay in HOLD with the new grant, or go to ARB if nothing is pending.
- `idle` is combinational: every packer empty, every FIFO empty, and state ARB.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_lane`=0, `m_bytes`=0, `overflow`=0, `rr_ptr`=0, state ARB, `idle`=1. Packers and FIFO pointers are cleared.
- Reset mid-operation discards all buffered bytes and any latched grant. It takes priority over every other event.
- Latency: a 4th byte presented in cycle t gives `m_valid`=1 in cycle t+2 (empty pipeline).
- Sustained throughput: one word per cycle while any FIFO stays non-empty and `m_ready`=1.
- `m_valid` never drops without a handshake. Outputs do not change while `m_valid && !m_ready`.
- The block never stalls its input; upstream has no backpressure. Loss is visible only through `overflow`.

## Configuration
- `NPU_OUTCOL_STATS_EN` defined: adds output `drop_cnt` [15:0]. It is a saturating count of all dropped bytes across lanes (multiple drops in one cycle add their total), reset to 0.
- Undefined: port and counter are absent; `overflow` flags only.

## Structure
- Shared package `npu_out_pkg`:
  - constants `OUT_LANES`=8, `OUT_BYTES_PER_WORD`=4;
  - arbiter state enum {ARB, HOLD};
  - packed word struct {data[31:0], bytes[2:0]}.
- Sub-module `out_lane_packer`, instantiated LANES times. It contains the byte packer, lane FIFO, overflow flag, and push/flush logic, and exposes head word, non-empty, pop.
- Top level holds the arbiter FSM, `rr_ptr`, and output registers.

## Test plan
- Lane 0 fed 0x11,0x22,0x33,0x44 in cycles 0–3, `m_ready`=1 → cycle 5: `m_data`=0x11223344, `m_lane`=0, `m_bytes`=4; one-cycle pulse, then `idle`=1.
- All 8 lanes receive 4 bytes simultaneously (lane k bytes = k) → 8 words emitted on consecutive cycles, lanes 0..7 in order. Next burst starts at the lane after the last served.
- `m_ready`=0 for 10 cycles while a word is held → `m_valid`, `m_data`, `m_lane` are constant; then one handshake per cycle.
- Lane 3 gets 3 bytes 0xA0,0xA1,0xA2, then `flush`=1 → word 0xA0A1A200, `m_bytes`=3, lane 3; `idle`=1 afterwards.
- Lane 5 with `m_ready`=0 fed 4*(FIFO_DEPTH+1) bytes → `overflow[2]` sets on the 5th word. Draining yields exactly FIFO_DEPTH words. With `NPU_OUTCOL_STATS_EN`, `drop_cnt`=1.
- Reset asserted mid-stream with pending words → next cycle `m_valid`=0, `overflow`=0, `idle`=1; the next word is packed from fresh bytes only.
